cursor_step_gen: RTL

CURSOR_STEP_GEN -- requirements
Module: cursor_step_gen

---
 rtl/cursor_step_gen_if.sv | 31 +++
 rtl/cursor_step_gen.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/cursor_step_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : cursor_step_gen_if
//  Brief    : Button inputs and step/direction/conflict outputs of the
//             cursor step generator.
//  Revision : 1.0  initial release
// ============================================================================
interface cursor_step_gen_if;
    logic btn_up;
    logic btn_down;
    logic step;
    logic up;
    logic conflict;

    modport master (
        output btn_up,
        output btn_down,
        input  step,
        input  up,
        input  conflict
    );

    modport slave (
        input  btn_up,
        input  btn_down,
        output step,
        output up,
        output conflict
    );
endinterface
`default_nettype wire

// File: rtl/cursor_step_gen.sv
`default_nettype none
// ============================================================================
//  Module   : cursor_step_gen
//  Brief    : Debounces two push buttons and emits single-cycle cursor step
//             pulses with hold-to-repeat; both buttons held locks stepping out.
//  Revision : 1.0  initial release
// ============================================================================
module cursor_step_gen #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned REPEAT_DELAY    = 64,
    parameter int unsigned REPEAT_RATE     = 16
) (
    input  wire logic           clk,
    input  wire logic           reset,
    cursor_step_gen_if.slave    bus
);

    localparam logic [15:0] c_DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [15:0] c_DLY_LAST  = 16'(REPEAT_DELAY - 1);
    localparam logic [15:0] c_RATE_LAST = 16'(REPEAT_RATE - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_FIRST  = 2'd1,
        S_REPEAT = 2'd2,
        S_LOCK   = 2'd3
    } state_t;

    // Bit 0 carries btn_up, bit 1 carries btn_down throughout.
    logic [1:0]  w_raw;
    logic [1:0]  r_sync1;
    logic [1:0]  r_sync2;
    logic [1:0]  r_db;
    logic [1:0]  r_db_prev;
    logic [15:0] r_db_cnt [2];
    logic [1:0]  w_press;

    state_t      r_state;
    state_t      w_next;
    logic        r_active;
    logic        w_active_nxt;
    logic [15:0] r_rep_cnt;
    logic [15:0] w_rep_cnt_nxt;
    logic        r_step;
    logic        w_step_nxt;
    logic        r_up;
    logic        w_up_nxt;
    logic        r_conflict;
    logic        w_act_held;
    logic        w_oth_held;

    assign w_raw   = {bus.btn_down, bus.btn_up};
    assign w_press = r_db & ~r_db_prev;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_db      <= '0;
            r_db_prev <= '0;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_sync1   <= w_raw;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db;
            for (int i = 0; i < 2; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == c_DB_LAST) begin
                    r_db[i]     <= r_sync2[i];
                    r_db_cnt[i] <= '0;
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 16'd1;
                end
            end
        end
    end

    assign w_act_held = r_db[r_active];
    assign w_oth_held = r_db[~r_active];

    always_comb begin
        w_next        = r_state;
        w_active_nxt  = r_active;
        w_rep_cnt_nxt = r_rep_cnt + 16'd1;
        w_step_nxt    = 1'b0;
        w_up_nxt      = r_up;
        case (r_state)
            S_IDLE: begin
                w_rep_cnt_nxt = '0;
                if (&r_db) begin
                    w_next = S_LOCK;
                end else if (w_press[0]) begin
                    w_next       = S_FIRST;
                    w_active_nxt = 1'b0;
                    w_step_nxt   = 1'b1;
                    w_up_nxt     = 1'b1;
                end else if (w_press[1]) begin
                    w_next       = S_FIRST;
                    w_active_nxt = 1'b1;
                    w_step_nxt   = 1'b1;
                    w_up_nxt     = 1'b0;
                end
            end
            S_FIRST, S_REPEAT: begin
                // Release takes precedence so a lost active button never steps.
                if (!w_act_held) begin
                    w_next        = S_IDLE;
                    w_rep_cnt_nxt = '0;
                end else if (w_oth_held) begin
                    w_next        = S_LOCK;
                    w_rep_cnt_nxt = '0;
                end else if (r_rep_cnt == ((r_state == S_FIRST) ? c_DLY_LAST : c_RATE_LAST)) begin
                    w_next        = S_REPEAT;
                    w_step_nxt    = 1'b1;
                    w_rep_cnt_nxt = '0;
                end
            end
            S_LOCK: begin
                w_rep_cnt_nxt = '0;
                if (r_db == 2'b00) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next        = S_IDLE;
                w_rep_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_IDLE;
            r_active   <= 1'b0;
            r_rep_cnt  <= '0;
            r_step     <= 1'b0;
            r_up       <= 1'b1;
            r_conflict <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_active   <= w_active_nxt;
            r_rep_cnt  <= w_rep_cnt_nxt;
            r_step     <= w_step_nxt;
            r_up       <= w_up_nxt;
            r_conflict <= (w_next == S_LOCK);
        end
    end

    assign bus.step     = r_step;
    assign bus.up       = r_up;
    assign bus.conflict = r_conflict;

endmodule
`default_nettype wire
